// File: rtl/pipeline_ctrl.sv
// Stall/flush sequencer for the five-stage pipeline: load-use, redirect, memory-wait
// and halt/drain control, plus a memory-wait watchdog and performance counters.
module pipeline_ctrl #(
  parameter int unsigned WAIT_LIMIT   = 255,
  parameter int unsigned DRAIN_CYCLES = 4
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [4:0]  id_rs1,
  input  logic [4:0]  id_rs2,
  input  logic        id_use_rs1,
  input  logic        id_use_rs2,
  input  logic [4:0]  ex_rd,
  input  logic        ex_mem_read,
  input  logic        ex_redirect,
  input  logic        mem_req,
  input  logic        mem_ready,
  input  logic        halt_req,
  output logic        pc_stall,
  output logic        if_id_stall,
  output logic        id_ex_stall,
  output logic        ex_mem_stall,
  output logic        if_id_flush,
  output logic        id_ex_flush,
  output logic        mem_wb_flush,
  output logic        halted,
  output logic        mem_timeout,
  output logic [31:0] stall_cycles,
  output logic [15:0] flush_count,
  output logic [1:0]  state_dbg
);

  typedef enum logic [1:0] {
    S_RUN      = 2'd0,
    S_MEM_WAIT = 2'd1,
    S_DRAIN    = 2'd2,
    S_HALTED   = 2'd3
  } state_e;

  localparam int unsigned   DW         = (DRAIN_CYCLES < 2) ? 1 : $clog2(DRAIN_CYCLES + 1);
  localparam logic [DW-1:0] DRAIN_LAST = DW'(DRAIN_CYCLES - 1);
  localparam logic [7:0]    WAIT_LIM8  = 8'(WAIT_LIMIT);

  state_e        state_q, state_d;
  state_e        prior_q, prior_d;
  logic [7:0]    wait_cnt_q, wait_cnt_d;
  logic [DW-1:0] drain_cnt_q, drain_cnt_d;
  logic          timeout_q, timeout_d;
  logic [31:0]   stall_cycles_q, stall_cycles_d;
  logic [15:0]   flush_count_q, flush_count_d;

  logic       is_halted, in_drain, quiet, mem_stall, redirect, load_use_hit, load_use, drain_last;
  logic [7:0] wait_inc;

  // A memory wait entered from DRAIN is still part of the drain: fetch stays off.
  assign is_halted    = (state_q == S_HALTED);
  assign in_drain     = (state_q == S_DRAIN) || ((state_q == S_MEM_WAIT) && (prior_q == S_DRAIN));
  assign quiet        = in_drain || is_halted;
  assign mem_stall    = mem_req && !mem_ready && !is_halted;
  assign redirect     = ex_redirect && !mem_stall && !is_halted;
  assign load_use_hit = ex_mem_read && (ex_rd != 5'd0) &&
                        ((id_use_rs1 && (id_rs1 == ex_rd)) || (id_use_rs2 && (id_rs2 == ex_rd)));
  assign load_use     = load_use_hit && !mem_stall && !ex_redirect && !is_halted;
  assign drain_last   = (drain_cnt_q == DRAIN_LAST);
  assign wait_inc     = (wait_cnt_q == 8'hFF) ? 8'hFF : wait_cnt_q + 8'd1;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q        <= S_RUN;
      prior_q        <= S_RUN;
      wait_cnt_q     <= 8'd0;
      drain_cnt_q    <= '0;
      timeout_q      <= 1'b0;
      stall_cycles_q <= 32'd0;
      flush_count_q  <= 16'd0;
    end else begin
      state_q        <= state_d;
      prior_q        <= prior_d;
      wait_cnt_q     <= wait_cnt_d;
      drain_cnt_q    <= drain_cnt_d;
      timeout_q      <= timeout_d;
      stall_cycles_q <= stall_cycles_d;
      flush_count_q  <= flush_count_d;
    end
  end

  always_comb begin
    state_d     = state_q;
    prior_d     = prior_q;
    wait_cnt_d  = wait_cnt_q;
    drain_cnt_d = drain_cnt_q;
    timeout_d   = timeout_q;
    if (in_drain && !mem_stall) drain_cnt_d = drain_cnt_q + DW'(1);
    case (state_q)
      S_RUN: begin
        if (mem_stall) begin
          state_d    = S_MEM_WAIT;
          prior_d    = S_RUN;
          wait_cnt_d = 8'd0;
        end else if (halt_req) begin
          state_d     = S_DRAIN;
          drain_cnt_d = '0;
        end
      end
      S_DRAIN: begin
        if (mem_stall) begin
          state_d    = S_MEM_WAIT;
          prior_d    = S_DRAIN;
          wait_cnt_d = 8'd0;
        end else if (drain_last) begin
          state_d = S_HALTED;
        end
      end
      S_MEM_WAIT: begin
        wait_cnt_d = wait_inc;
        if (wait_inc >= WAIT_LIM8) timeout_d = 1'b1;
        // The ready cycle of a drain-time wait counts as a drain cycle.
        if (!mem_stall) state_d = ((prior_q == S_DRAIN) && drain_last) ? S_HALTED : prior_q;
      end
      S_HALTED: state_d = S_HALTED;
      default:  state_d = S_RUN;
    endcase
  end

  // Outputs are forced low while rst is high, even if the inputs still request a stall.
  always_comb begin
    pc_stall     = 1'b0;
    if_id_stall  = 1'b0;
    id_ex_stall  = 1'b0;
    ex_mem_stall = 1'b0;
    if_id_flush  = 1'b0;
    id_ex_flush  = 1'b0;
    mem_wb_flush = 1'b0;
    if (!rst) begin
      pc_stall     = mem_stall || load_use || quiet;
      if_id_stall  = mem_stall || load_use;
      id_ex_stall  = mem_stall;
      ex_mem_stall = mem_stall;
      mem_wb_flush = mem_stall;
      // A held IF/ID (memory or load-use) wins over the drain bubble.
      if_id_flush  = redirect || (quiet && !mem_stall && !load_use);
      id_ex_flush  = redirect || load_use;
    end
  end

  always_comb begin
    stall_cycles_d = stall_cycles_q + {31'd0, pc_stall};
    flush_count_d  = flush_count_q;
    if (redirect && (flush_count_q != 16'hFFFF)) flush_count_d = flush_count_q + 16'd1;
  end

  assign halted       = is_halted;
  assign mem_timeout  = timeout_q;
  assign stall_cycles = stall_cycles_q;
  assign flush_count  = flush_count_q;
  assign state_dbg    = state_q;

endmodule

// File: tb/tb_pipeline_ctrl.sv
// Directed scenarios plus random traffic for pipeline_ctrl, checked cycle by cycle
// against a behavioural model of the stall/flush rules.
module tb_pipeline_ctrl;

  localparam int unsigned WAIT_LIMIT   = 4;
  localparam int unsigned DRAIN_CYCLES = 4;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [4:0]  id_rs1, id_rs2, ex_rd;
  logic        id_use_rs1, id_use_rs2, ex_mem_read, ex_redirect, mem_req, mem_ready, halt_req;
  logic        pc_stall, if_id_stall, id_ex_stall, ex_mem_stall;
  logic        if_id_flush, id_ex_flush, mem_wb_flush, halted, mem_timeout;
  logic [31:0] stall_cycles;
  logic [15:0] flush_count;
  logic [1:0]  state_dbg;

  int n_checks = 0;
  int n_pass   = 0;
  int n_fail   = 0;

  // Behavioural model: fetch stopped while draining/halted, an open memory wait,
  // drained-cycle tally and the counters.
  bit          m_halted, m_draining, m_in_wait, m_timeout;
  int          m_drained, m_wait_cnt;
  logic [31:0] m_stalls;
  logic [15:0] m_flushes;

  pipeline_ctrl #(.WAIT_LIMIT(WAIT_LIMIT), .DRAIN_CYCLES(DRAIN_CYCLES)) dut (
    .clk(clk), .rst(rst),
    .id_rs1(id_rs1), .id_rs2(id_rs2), .id_use_rs1(id_use_rs1), .id_use_rs2(id_use_rs2),
    .ex_rd(ex_rd), .ex_mem_read(ex_mem_read), .ex_redirect(ex_redirect),
    .mem_req(mem_req), .mem_ready(mem_ready), .halt_req(halt_req),
    .pc_stall(pc_stall), .if_id_stall(if_id_stall), .id_ex_stall(id_ex_stall),
    .ex_mem_stall(ex_mem_stall), .if_id_flush(if_id_flush), .id_ex_flush(id_ex_flush),
    .mem_wb_flush(mem_wb_flush), .halted(halted), .mem_timeout(mem_timeout),
    .stall_cycles(stall_cycles), .flush_count(flush_count), .state_dbg(state_dbg)
  );

  always #5 clk = ~clk;

  task automatic chk1(input string tag, input logic obs, input logic exp);
    n_checks++;
    assert (obs === exp) n_pass++;
    else begin
      n_fail++;
      $error("FAIL %s: got %b expected %b", tag, obs, exp);
    end
  endtask

  task automatic chk32(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) n_pass++;
    else begin
      n_fail++;
      $error("FAIL %s: got %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic set_idle();
    id_rs1 = 5'd0; id_rs2 = 5'd0; ex_rd = 5'd0;
    id_use_rs1 = 1'b0; id_use_rs2 = 1'b0; ex_mem_read = 1'b0; ex_redirect = 1'b0;
    mem_req = 1'b0; mem_ready = 1'b0; halt_req = 1'b0;
  endtask

  task automatic model_reset();
    m_halted = 0; m_draining = 0; m_in_wait = 0; m_timeout = 0;
    m_drained = 0; m_wait_cnt = 0; m_stalls = 32'd0; m_flushes = 16'd0;
  endtask

  task automatic chk_all_low(input string tag);
    chk1({tag, "_pc"}, pc_stall, 1'b0);
    chk1({tag, "_ifid_s"}, if_id_stall, 1'b0);
    chk1({tag, "_idex_s"}, id_ex_stall, 1'b0);
    chk1({tag, "_exmem_s"}, ex_mem_stall, 1'b0);
    chk1({tag, "_ifid_f"}, if_id_flush, 1'b0);
    chk1({tag, "_idex_f"}, id_ex_flush, 1'b0);
    chk1({tag, "_memwb_f"}, mem_wb_flush, 1'b0);
    chk1({tag, "_halted"}, halted, 1'b0);
    chk1({tag, "_timeout"}, mem_timeout, 1'b0);
    chk32({tag, "_stall_cnt"}, stall_cycles, 32'd0);
    chk32({tag, "_flush_cnt"}, 32'(flush_count), 32'd0);
  endtask

  // Called at posedge+1 with inputs applied; checks the cycle, advances the model, clocks.
  task automatic step();
    bit mstall, redir, lu, quiet, was_wait;
    logic e_pc, e_ifid, e_ifidf, e_idexf;
    #2;
    mstall = mem_req && !mem_ready && !m_halted;
    redir  = ex_redirect && !mstall && !m_halted;
    lu     = ex_mem_read && (ex_rd != 5'd0) &&
             ((id_use_rs1 && id_rs1 == ex_rd) || (id_use_rs2 && id_rs2 == ex_rd)) &&
             !mstall && !ex_redirect && !m_halted;
    quiet  = m_draining || m_halted;
    e_pc    = mstall || lu || quiet;
    e_ifid  = mstall || lu;
    e_ifidf = redir || (quiet && !mstall && !lu);
    e_idexf = redir || lu;
    chk1("pc_stall", pc_stall, e_pc);
    chk1("if_id_stall", if_id_stall, e_ifid);
    chk1("id_ex_stall", id_ex_stall, mstall);
    chk1("ex_mem_stall", ex_mem_stall, mstall);
    chk1("mem_wb_flush", mem_wb_flush, mstall);
    chk1("if_id_flush", if_id_flush, e_ifidf);
    chk1("id_ex_flush", id_ex_flush, e_idexf);
    chk1("halted", halted, m_halted);
    chk1("mem_timeout", mem_timeout, m_timeout);
    chk32("stall_cycles", stall_cycles, m_stalls);
    chk32("flush_count", 32'(flush_count), 32'(m_flushes));
    m_stalls += 32'(e_pc);
    if (!m_halted) begin
      if (redir && m_flushes != 16'hFFFF) m_flushes++;
      was_wait = m_in_wait;
      if (was_wait) begin
        if (m_wait_cnt < 255) m_wait_cnt++;
        if (m_wait_cnt >= int'(WAIT_LIMIT)) m_timeout = 1;
      end
      if (mstall) begin
        if (!was_wait) begin
          m_in_wait = 1;
          m_wait_cnt = 0;
        end
      end else begin
        m_in_wait = 0;
        if (m_draining) begin
          m_drained++;
          if (m_drained == int'(DRAIN_CYCLES)) begin
            m_draining = 0;
            m_halted = 1;
          end
        end else if (halt_req && !was_wait) begin
          m_draining = 1;
          m_drained = 0;
        end
      end
    end
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    set_idle();
    @(posedge clk);
    #1;
    rst = 1'b0;
    model_reset();
  endtask

  initial begin
    set_idle();
    model_reset();
    #3;
    chk_all_low("reset");
    chk32("reset_state", 32'(state_dbg), 32'd0);
    @(posedge clk);
    #1;
    rst = 1'b0;

    // Load-use on rs1, then the same with ex_rd = x0.
    ex_mem_read = 1'b1; ex_rd = 5'd5; id_rs1 = 5'd5; id_use_rs1 = 1'b1;
    step();
    chk32("lu_stall_cnt", stall_cycles, 32'd1);
    ex_rd = 5'd0; id_rs1 = 5'd0;
    step();
    set_idle();
    step();
    chk32("lu_x0_stall_cnt", stall_cycles, 32'd1);

    // Redirect together with a load-use hazard.
    do_reset();
    ex_redirect = 1'b1; ex_mem_read = 1'b1; ex_rd = 5'd7; id_rs2 = 5'd7; id_use_rs2 = 1'b1;
    #1;
    chk1("rd_lu_pc", pc_stall, 1'b0);
    chk1("rd_lu_idex_f", id_ex_flush, 1'b1);
    step();
    set_idle();
    chk32("rd_flush_cnt", 32'(flush_count), 32'd1);
    step();

    // Three-cycle memory wait.
    do_reset();
    mem_req = 1'b1; mem_ready = 1'b0;
    for (int i = 0; i < 3; i++) step();
    mem_ready = 1'b1;
    step();
    set_idle();
    chk32("mem_stall_cnt", stall_cycles, 32'd3);
    step();

    // Watchdog: ready held low for ten cycles.
    do_reset();
    mem_req = 1'b1; mem_ready = 1'b0;
    for (int i = 1; i <= 10; i++) begin
      step();
      chk1("timeout_edge", mem_timeout, logic'(i >= 5));
    end
    mem_ready = 1'b1;
    step();
    set_idle();
    for (int i = 0; i < 3; i++) step();
    chk1("timeout_sticky", mem_timeout, 1'b1);

    // Halt with a two-cycle memory wait inside DRAIN.
    do_reset();
    for (int e = 1; e <= 7; e++) begin
      halt_req  = logic'(e == 1);
      mem_req   = logic'(e >= 3 && e <= 5);
      mem_ready = logic'(e == 5);
      step();
      chk1("halt_edge", halted, logic'(e == 7));
    end
    set_idle();
    mem_req = 1'b1;
    for (int i = 0; i < 2; i++) step();
    #2;
    rst = 1'b1;
    #1;
    chk1("halt_async_rst", halted, 1'b0);
    chk1("halt_async_pc", pc_stall, 1'b0);
    @(posedge clk);
    #1;
    rst = 1'b0;
    model_reset();
    set_idle();
    step();

    // Reset pulled mid-MEM_WAIT while memory still requests a stall.
    mem_req = 1'b1; mem_ready = 1'b0;
    step();
    step();
    #2;
    rst = 1'b1;
    #1;
    chk_all_low("memwait_rst");
    @(posedge clk);
    #1;
    rst = 1'b0;
    model_reset();
    set_idle();
    step();
    step();

    // Random traffic; resets now and then once halted.
    for (int i = 0; i < 800; i++) begin
      if (m_halted && $urandom_range(0, 3) == 0) do_reset();
      ex_rd       = 5'($urandom_range(0, 3));
      id_rs1      = 5'($urandom_range(0, 3));
      id_rs2      = 5'($urandom_range(0, 3));
      id_use_rs1  = logic'($urandom_range(0, 1));
      id_use_rs2  = logic'($urandom_range(0, 1));
      ex_mem_read = logic'($urandom_range(0, 99) < 40);
      ex_redirect = logic'($urandom_range(0, 99) < 15);
      mem_req     = logic'($urandom_range(0, 99) < 30);
      mem_ready   = logic'($urandom_range(0, 99) < 45);
      halt_req    = logic'($urandom_range(0, 99) < 3);
      step();
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/pipeline_ctrl.md
# pipeline_ctrl

Central stall/flush sequencer for the five-stage pipeline: it decides, every cycle, which pipeline registers (PC, IF/ID, ID/EX, EX/MEM, MEM/WB) hold, advance or take a bubble. It resolves load-use hazards, EX-stage control-flow redirects, multi-cycle data-memory accesses and a halt/drain request. It keeps a small state machine, a memory-wait watchdog and performance counters. Stall/flush outputs are combinational from registered state plus current inputs and drive the pipeline registers' hold and clear controls directly.

## Interface
- WAIT_LIMIT, 255: memory-wait cycles before `mem_timeout` sets (1..255).
- DRAIN_CYCLES, 4: cycles spent in DRAIN before HALTED.
- clk  in  1  pipeline clock, all state on rising edge.
- rst  in  1  asynchronous, active-high reset.
- id_rs1, id_rs2  in  5  source register indices of the instruction in ID.
- id_use_rs1, id_use_rs2  in  1  ID instruction actually reads rs1/rs2.
- ex_rd  in  5  destination index of the instruction in EX.
- ex_mem_read  in  1  EX instruction is a load.
- ex_redirect  in  1  EX resolved a taken branch/jump (wrong-path fetch).
- mem_req  in  1  MEM stage instruction accesses data memory.
- mem_ready  in  1  data memory completes the access this cycle.
- halt_req  in  1  request to stop fetching and drain.
- pc_stall, if_id_stall, id_ex_stall, ex_mem_stall  out  1  hold the register.
- if_id_flush, id_ex_flush, mem_wb_flush  out  1  load a bubble (all-zero control) into the register.
- halted  out  1  pipeline drained and stopped.
- mem_timeout  out  1  sticky: a memory wait reached WAIT_LIMIT.
- stall_cycles  out  32  count of cycles with `pc_stall`=1, wraps at 2^32.
- flush_count  out  16  count of redirect flushes, saturates at 0xFFFF.

## Operation
- States: RUN, MEM_WAIT, DRAIN, HALTED. Reset to RUN; all counters, `halted`, `mem_timeout` = 0. With idle inputs in RUN, every stall/flush output is 0.
- Memory stall (highest priority, any state except HALTED): `mem_req && !mem_ready` -> pc/if_id/id_ex/ex_mem stall = 1, mem_wb_flush = 1. Redirect and load-use actions are suppressed that cycle (EX holds, so they re-present later). RUN/DRAIN -> MEM_WAIT at the edge; return to the saved prior state (RUN or DRAIN) at the edge where `mem_ready`=1.
- Wait counter (8-bit): clears on entering MEM_WAIT, increments each MEM_WAIT cycle, saturates; reaching WAIT_LIMIT sets `mem_timeout` (sticky until rst). No abort; the wait continues.
- Redirect (no memory stall): `ex_redirect` -> if_id_flush = 1, id_ex_flush = 1; PC not stalled (loads target). flush_count += 1. Overrides load-use (ID instruction is wrong-path).
- Load-use (no memory stall, no redirect): `ex_mem_read && ex_rd != 0 && ((id_use_rs1 && id_rs1 == ex_rd) || (id_use_rs2 && id_rs2 == ex_rd))` -> pc_stall = 1, if_id_stall = 1, id_ex_flush = 1. Exactly one bubble; no state change.
- Halt: `halt_req` in RUN with no memory stall -> DRAIN. In DRAIN and HALTED: pc_stall = 1, if_id_flush = 1 (no new instructions). DRAIN counter counts DRAIN_CYCLES non-memory-stalled cycles, paused during MEM_WAIT, then -> HALTED. HALTED: `halted` = 1, memory stall ignored, exit only via rst. `halt_req` outside RUN ignored.
- rst mid-operation (any state, any cycle): immediate return to reset values; outputs drop to 0 without a clock edge.

## Timing
- Stall/flush: zero-cycle (combinational) response to inputs in the same cycle.
- `mem_req && mem_ready` in the same cycle: no stall.
- MEM_WAIT exit: stalls deassert in the `mem_ready` cycle; pipeline advances at that edge.
- `halted` rises DRAIN_CYCLES+1 edges after the `halt_req` cycle, plus any memory-wait cycles.
- Counters update at the edge closing the counted cycle.

## Test plan
- Load-use: ex_mem_read=1, ex_rd=5, id_rs1=5, id_use_rs1=1 for 1 cycle -> pc_stall=if_id_stall=id_ex_flush=1 that cycle only; stall_cycles=1. Repeat with ex_rd=0 -> no stall.
- Redirect + load-use together -> if_id_flush=id_ex_flush=1, pc_stall=0, flush_count=1.
- Memory wait: mem_req=1, mem_ready=0 for 3 cycles then 1 -> four stall signals and mem_wb_flush high 3 cycles, drop in the ready cycle; state back to RUN; stall_cycles=3.
- Timeout: WAIT_LIMIT=4, mem_ready low 10 cycles -> mem_timeout=1 after the 4th MEM_WAIT cycle, stays 1 after ready until rst.
- Halt with 2-cycle memory wait during DRAIN -> halted rises at edge 7 after halt_req (5 + 2); pc_stall held; rst clears halted asynchronously.
- rst asserted mid-MEM_WAIT between clock edges -> all outputs 0 immediately; next cycle in RUN with idle inputs, no stalls.
